// File: rtl/weight_load_sequencer_if.sv
// Host word stream between the host/DMA side and the weight load sequencer.
// The host (master) offers 32-bit words with s_valid; the sequencer (slave)
// accepts them with s_ready. A word moves when s_valid & s_ready.
interface weight_load_sequencer_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/weight_load_sequencer.sv
// Weight load sequencer: parses framed host records
//   layer_no, neuron_no, count, count weight words [, checksum]
// and broadcasts each weight word as a one-cycle strobe on the shared
// config bus, with layer/neuron numbers held stable for the whole record.
// Records with count==0, count>MAX_WEIGHTS or layer_no>=NUM_LAYERS raise
// load_err; oversize/bad-layer records are drained without any strobes.
// Optional feature macro: LOAD_CHECKSUM_EN adds a trailing checksum word
// (32-bit wrapping sum of the weight words) to every record.
module weight_load_sequencer #(
    parameter int NUM_LAYERS  = 4,
    parameter int MAX_WEIGHTS = 784,
    parameter int CNT_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    weight_load_sequencer_if.slave  s,
    output logic                    weight_valid,
    output logic [31:0]             weight_value,
    output logic [31:0]             config_layer_no,
    output logic [31:0]             config_neuron_no,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

`ifdef LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LAYER, S_NEURON, S_COUNT, S_DATA, S_SKIP, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LAYER, S_NEURON, S_COUNT, S_DATA, S_SKIP
    } state_t;
`endif

    state_t                state_q, state_d;
    logic                  ready_q;
    logic                  wv_q, wv_d;
    logic [31:0]           wval_q, wval_d;
    logic [31:0]           layer_q, layer_d;
    logic [31:0]           neuron_q, neuron_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]           csum_q, csum_d;
`endif

    logic xfer;
    logic last_word;

    assign xfer      = s.s_valid & ready_q;
    assign last_word = (cnt_q == CNT_BITS'(1));

    // Next-state and next-output decode for the record parser.
    always_comb begin
        state_d  = state_q;
        wv_d     = 1'b0;
        wval_d   = wval_q;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        done_d   = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
`ifdef LOAD_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (xfer) begin
            unique case (state_q)
                S_LAYER: begin
                    layer_d = s.s_data;
                    err_d   = 1'b0;
`ifdef LOAD_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = S_NEURON;
                end
                S_NEURON: begin
                    neuron_d = s.s_data;
                    state_d  = S_COUNT;
                end
                S_COUNT: begin
                    if (s.s_data == 32'd0) begin
                        // Empty record: nothing follows, not even a checksum.
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_LAYER;
                    end else if ((s.s_data > 32'(MAX_WEIGHTS)) ||
                                 (layer_q >= 32'(NUM_LAYERS))) begin
                        err_d   = 1'b1;
                        cnt_d   = CNT_BITS'(s.s_data);
                        state_d = S_SKIP;
                    end else begin
                        cnt_d   = CNT_BITS'(s.s_data);
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    wv_d   = 1'b1;
                    wval_d = s.s_data;
                    cnt_d  = cnt_q - CNT_BITS'(1);
`ifdef LOAD_CHECKSUM_EN
                    csum_d = csum_q + s.s_data;
                    if (last_word) begin
                        state_d = S_CSUM;
                    end
`else
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = S_LAYER;
                    end
`endif
                end
                S_SKIP: begin
                    cnt_d = cnt_q - CNT_BITS'(1);
`ifdef LOAD_CHECKSUM_EN
                    if (last_word) begin
                        state_d = S_CSUM;
                    end
`else
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = S_LAYER;
                    end
`endif
                end
`ifdef LOAD_CHECKSUM_EN
                S_CSUM: begin
                    // A skipped record already has err set, so its checksum
                    // word cannot change the outcome.
                    if (s.s_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = S_LAYER;
                end
`endif
                default: state_d = S_LAYER;
            endcase
        end
        // busy stays high through the load_done cycle.
        busy_d = (state_d != S_LAYER) || done_d;
    end

    // State and registered outputs; reset aborts any record in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_LAYER;
            ready_q  <= 1'b0;
            wv_q     <= 1'b0;
            wval_q   <= '0;
            layer_q  <= '0;
            neuron_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef LOAD_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= 1'b1;
            wv_q     <= wv_d;
            wval_q   <= wval_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`ifdef LOAD_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign s.s_ready        = ready_q;
    assign weight_valid     = wv_q;
    assign weight_value     = wval_q;
    assign config_layer_no  = layer_q;
    assign config_neuron_no = neuron_q;
    assign busy             = busy_q;
    assign load_done        = done_q;
    assign load_err         = err_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer: a per-cycle vector table for the
// record-level behaviour plus hand-written sequences for reset and long
// skip/boundary records.
module tb_weight_load_sequencer;

    logic        clk;
    logic        reset;
    logic        weight_valid;
    logic [31:0] weight_value;
    logic [31:0] config_layer_no;
    logic [31:0] config_neuron_no;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    weight_load_sequencer_if bus ();

    weight_load_sequencer #(
        .NUM_LAYERS  (4),
        .MAX_WEIGHTS (784),
        .CNT_BITS    (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s                (bus),
        .weight_valid     (weight_valid),
        .weight_value     (weight_value),
        .config_layer_no  (config_layer_no),
        .config_neuron_no (config_neuron_no),
        .busy             (busy),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        wv;
        logic [31:0] wval;
        logic [31:0] lay;
        logic [31:0] neu;
        logic        done;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] WA = 32'h1111_1111;
    localparam logic [31:0] WB = 32'h2222_2222;
    localparam logic [31:0] WC = 32'h3333_3333;
    localparam logic [31:0] WX = 32'hDEAD_BEEF;

    task automatic add(input logic v, input logic [31:0] d, input logic wv,
                       input logic [31:0] wval, input logic [31:0] lay,
                       input logic [31:0] neu, input logic done,
                       input logic err, input logic bsy);
        vec_t e;
        e.v = v; e.d = d; e.wv = wv; e.wval = wval; e.lay = lay; e.neu = neu;
        e.done = done; e.err = err; e.busy = bsy;
        tbl.push_back(e);
    endtask

    function automatic logic [100:0] outs();
        return {bus.s_ready, weight_valid, weight_value, config_layer_no,
                config_neuron_no, load_done, load_err, busy};
    endfunction

    task automatic check(input string nm, input logic [100:0] act,
                         input logic [100:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Drive one word (or an idle cycle) and sample just after the edge.
    task automatic drive(input logic v, input logic [31:0] d);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic v, input logic [31:0] d,
                        input logic wv, input logic [31:0] wval,
                        input logic [31:0] lay, input logic [31:0] neu,
                        input logic done, input logic err, input logic bsy);
        drive(v, d);
        check(nm, outs(), {1'b1, wv, wval, lay, neu, done, err, bsy});
    endtask

    int n_wv;
    int n_done;

    initial begin
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #2 reset = 1'b0;
        #1;
        check("reset_state", outs(), '0);
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", {100'd0, bus.s_ready}, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_before_edge", {100'd0, bus.s_ready}, '0);
        @(posedge clk);
        #1;
        check("ready_after_release", outs(), {1'b1, 100'd0});

`ifndef LOAD_CHECKSUM_EN
        // {1,5,3,A,B,C} back-to-back
        add(1, 1,  0, 0,  1, 0, 0, 0, 1);
        add(1, 5,  0, 0,  1, 5, 0, 0, 1);
        add(1, 3,  0, 0,  1, 5, 0, 0, 1);
        add(1, WA, 1, WA, 1, 5, 0, 0, 1);
        add(1, WB, 1, WB, 1, 5, 0, 0, 1);
        add(1, WC, 1, WC, 1, 5, 1, 0, 1);
        add(0, 0,  0, WC, 1, 5, 0, 0, 0);
        // same record with a 2-cycle s_valid gap between B and C
        add(1, 1,  0, WC, 1, 5, 0, 0, 1);
        add(1, 5,  0, WC, 1, 5, 0, 0, 1);
        add(1, 3,  0, WC, 1, 5, 0, 0, 1);
        add(1, WA, 1, WA, 1, 5, 0, 0, 1);
        add(1, WB, 1, WB, 1, 5, 0, 0, 1);
        add(0, 0,  0, WB, 1, 5, 0, 0, 1);
        add(0, 0,  0, WB, 1, 5, 0, 0, 1);
        add(1, WC, 1, WC, 1, 5, 1, 0, 1);
        add(0, 0,  0, WC, 1, 5, 0, 0, 0);
        // count==0 record {0,2,0}
        add(1, 0,  0, WC, 0, 5, 0, 0, 1);
        add(1, 2,  0, WC, 0, 2, 0, 0, 1);
        add(1, 0,  0, WC, 0, 2, 1, 1, 1);
        add(0, 0,  0, WC, 0, 2, 0, 1, 0);
        // {0,2,1,X}: header clears the error
        add(1, 0,  0, WC, 0, 2, 0, 0, 1);
        add(1, 2,  0, WC, 0, 2, 0, 0, 1);
        add(1, 1,  0, WC, 0, 2, 0, 0, 1);
        add(1, WX, 1, WX, 0, 2, 1, 0, 1);
        add(0, 0,  0, WX, 0, 2, 0, 0, 0);
        // layer_no==NUM_LAYERS: 3 words drained, no strobes
        add(1, 4,  0, WX, 4, 2, 0, 0, 1);
        add(1, 0,  0, WX, 4, 0, 0, 0, 1);
        add(1, 3,  0, WX, 4, 0, 0, 1, 1);
        add(1, WA, 0, WX, 4, 0, 0, 1, 1);
        add(1, WB, 0, WX, 4, 0, 0, 1, 1);
        add(1, WC, 0, WX, 4, 0, 1, 1, 1);
        add(0, 0,  0, WX, 4, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].wv,
                 tbl[i].wval, tbl[i].lay, tbl[i].neu, tbl[i].done,
                 tbl[i].err, tbl[i].busy);
        end

        // count=800 exceeds MAX_WEIGHTS: 800 words drained silently
        drive(1, 0); drive(1, 1); drive(1, 800);
        n_wv = 0; n_done = 0;
        for (int i = 0; i < 800; i++) begin
            drive(1, 32'(i + 100));
            n_wv   += int'(weight_valid);
            n_done += int'(load_done);
        end
        check("skip800_err", {100'd0, load_err}, {100'd0, 1'b1});
        drive(0, 0);
        n_wv   += int'(weight_valid);
        n_done += int'(load_done);
        check("skip800_strobes", 101'(n_wv), 101'd0);
        check("skip800_done", 101'(n_done), 101'd1);
        check("skip800_idle", {99'd0, busy, load_err}, {99'd0, 1'b0, 1'b1});

        // count=MAX_WEIGHTS is the largest legal record
        drive(1, 2); drive(1, 9); drive(1, 784);
        n_wv = 0; n_done = 0;
        for (int i = 0; i < 784; i++) begin
            drive(1, 32'(i + 1));
            n_wv   += int'(weight_valid);
            n_done += int'(load_done);
        end
        check("max_last", {68'd0, weight_value, load_done},
              {68'd0, 32'd784, 1'b1});
        drive(0, 0);
        n_done += int'(load_done);
        check("max_strobes", 101'(n_wv), 101'd784);
        check("max_done", 101'(n_done), 101'd1);
        check("max_err", {100'd0, load_err}, '0);
`else
        // checksum matches
        step("cs_ok_h0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("cs_ok_h1", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("cs_ok_h2", 1, 2, 0, 0, 0, 0, 0, 0, 1);
        step("cs_ok_w0", 1, 1, 1, 1, 0, 0, 0, 0, 1);
        step("cs_ok_w1", 1, 2, 1, 2, 0, 0, 0, 0, 1);
        step("cs_ok_cs", 1, 3, 0, 2, 0, 0, 1, 0, 1);
        step("cs_ok_id", 0, 0, 0, 2, 0, 0, 0, 0, 0);
        // checksum mismatch
        step("cs_bad_h0", 1, 0, 0, 2, 0, 0, 0, 0, 1);
        step("cs_bad_h1", 1, 0, 0, 2, 0, 0, 0, 0, 1);
        step("cs_bad_h2", 1, 2, 0, 2, 0, 0, 0, 0, 1);
        step("cs_bad_w0", 1, 1, 1, 1, 0, 0, 0, 0, 1);
        step("cs_bad_w1", 1, 2, 1, 2, 0, 0, 0, 0, 1);
        step("cs_bad_cs", 1, 4, 0, 2, 0, 0, 1, 1, 1);
        step("cs_bad_id", 0, 0, 0, 2, 0, 0, 0, 1, 0);
`endif

        // reset after the 2nd of 3 data words, then a clean record
        drive(1, 2); drive(1, 3); drive(1, 3);
        drive(1, WA); drive(1, WB);
        check("pre_abort", {67'd0, weight_valid, weight_value, busy},
              {67'd0, 1'b1, WB, 1'b1});
        @(negedge clk);
        bus.s_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_async", outs(), '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_release", outs(), {1'b1, 100'd0});
        step("rl_h0", 1, 3,  0, 0,  3, 0, 0, 0, 1);
        step("rl_h1", 1, 7,  0, 0,  3, 7, 0, 0, 1);
        step("rl_h2", 1, 2,  0, 0,  3, 7, 0, 0, 1);
        step("rl_w0", 1, WA, 1, WA, 3, 7, 0, 0, 1);
`ifndef LOAD_CHECKSUM_EN
        step("rl_w1", 1, WB, 1, WB, 3, 7, 1, 0, 1);
`else
        step("rl_w1", 1, WB, 1, WB, 3, 7, 0, 0, 1);
        step("rl_cs", 1, WA + WB, 0, WB, 3, 7, 1, 0, 1);
`endif
        step("rl_id", 0, 0,  0, WB, 3, 7, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
